fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Next-generation forwarding and hazard controller for the 5-stage RV32 pipeline.
- Resolves forwarding in ID against the instructions in EX, MEM and WB, then registers per-source select codes into the ID/EX boundary.
- Generates load-use bubbles with a parametrised bubble count, and freezes on data-memory wait states.
- Supports NUM_SRC source operands, so a third read port can be added for future extensions.

Parameters:
- NUM_SRC, 2: number of source register operands per instruction (1..3).
- REG_ADDR_W, 5: register index width.
- LOAD_BUBBLES, 1: bubbles inserted on a load-use hazard (1..3).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_id_valid  in  1  ID holds a valid instruction
- i_id_rs  in  NUM_SRC*REG_ADDR_W  source indices; slot k = bits [k*REG_ADDR_W +: REG_ADDR_W]
- i_id_rs_used  in  NUM_SRC  slot k is actually read
- i_ex_rd, i_mem_rd, i_wb_rd  in  REG_ADDR_W each  destination of the instruction in EX / MEM / WB
- i_ex_reg_write, i_mem_reg_write, i_wb_reg_write  in  1 each  register-write enables
- i_ex_mem_read  in  1  EX instruction is a load
- i_dmem_req  in  1  MEM stage issues a data-memory access
- i_dmem_ready  in  1  data memory completes this cycle
- i_flush  in  1  branch/jump redirect; kill IF/ID and ID/EX
- o_fwd_sel  out  NUM_SRC*2  registered select per slot, consumed by the EX muxes: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB write data, 11 WB write-through
- o_stall_id  out  1  hold PC and IF/ID
- o_bubble_ex  out  1  load NOP into ID/EX
- o_freeze  out  1  hold all pipeline registers (memory wait)

Behaviour:
- Reset state: FSM=RUN, bubble counter=0, o_fwd_sel=0. Combinational outputs are 0 while i_rst is high.
- Match rule for slot k against a stage: i_id_valid & rs_used[k] & reg_write & rd!=0 & rd==rs[k].
- Next select priority is EX (01) > MEM (10) > WB (11) > 00.
- Load-use hazard: any slot matches EX with i_ex_mem_read=1.
- FSM states: RUN, BUBBLE, WAIT.
  - RUN:
    - If i_dmem_req & !i_dmem_ready: o_freeze=1, go to WAIT.
    - Else if i_flush: o_fwd_sel<=0.
    - Else if load-use hazard: o_stall_id=1, o_bubble_ex=1, o_fwd_sel<=0. If LOAD_BUBBLES>1, load counter with LOAD_BUBBLES-1 and go to BUBBLE.
    - Else: o_fwd_sel<=next select.
  - BUBBLE:
    - o_stall_id=1, o_bubble_ex=1, o_fwd_sel<=0, counter decrements.
    - Return to RUN when the counter reaches 0.
    - i_flush aborts immediately to RUN with counter=0.
    - A memory wait still takes priority and goes to WAIT. The counter is preserved and resumes on exit.
  - WAIT:
    - o_freeze=1; o_fwd_sel and counter hold.
    - On i_dmem_ready=1, o_freeze=0 that same cycle. Return to BUBBLE if counter!=0, else RUN.
- Latency: o_fwd_sel updates on the edge where ID advances to EX (one cycle). Stall, bubble and freeze are combinational from state plus inputs.
- Simultaneous events:
  - Flush beats load-use.
  - Memory wait beats flush; upstream holds i_flush until the freeze drops.
- rd=0 never forwards and never stalls.
- Reset mid-operation returns to RUN, counter=0, o_fwd_sel=0 on the next edge.

Optional Feature:
- Macro FWD_HAZARD_PERF_EN.
- Defined: adds 32-bit wrapping outputs o_perf_bubbles (bubble cycles), o_perf_freeze (freeze cycles) and o_perf_fwd (edges with any nonzero next select). All clear on i_rst.
- Undefined: ports and counters absent, no logic generated.

Decomposition:
- Shared pipeline package holds:
  - Enum fwd_sel_e: FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB.
  - Enum hz_state_e: RUN, BUBBLE, WAIT.
  - Constant REG_ZERO.
- One sub-module, fwd_match, per slot: combinational match/priority encoder producing the next select and a load-use flag. It is instantiated NUM_SRC times in a generate loop.

Test Plan:
1. Forward from EX/MEM: ID rs1=5, EX rd=5 wr=1 non-load -> next edge o_fwd_sel[1:0]=01, no stall.
2. Load-use with LOAD_BUBBLES=1: EX load rd=7, ID rs2=7 used -> one cycle stall_id=bubble_ex=1. Then load in MEM -> o_fwd_sel[3:2]=10.
3. Load-use with LOAD_BUBBLES=3 and a dmem wait of 2 cycles during the second bubble -> 3 bubbles total, freeze=1 for 2 cycles, counter preserved.
4. x0 and unused slots: EX rd=0 wr=1 with rs1=0; rs_used[1]=0 with matching rd -> sel 00, no stall.
5. Priority: EX, MEM and WB all write rd=9, rs1=9 -> 01. Remove the EX write -> 10. Remove the MEM write -> 11.
6. Flush during BUBBLE -> state RUN and counter=0 next edge. i_rst asserted mid-WAIT -> all outputs 0, o_fwd_sel=0.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl_pkg
//  Purpose  : Shared pipeline types for the forwarding / hazard controller:
//             forwarding select codes, hazard FSM states, the x0 index.
//  Revision : 1.0  initial release
// ============================================================================
package fwd_hazard_ctrl_pkg;

    // Select code per source slot, consumed by the EX operand muxes.
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,  // register file
        FWD_EXMEM = 2'b01,  // EX/MEM ALU result
        FWD_MEMWB = 2'b10,  // MEM/WB write data
        FWD_WB    = 2'b11   // WB write-through
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        WAIT   = 2'd2
    } hz_state_e;

    // x0 is hardwired to zero: it never forwards and never stalls.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl_if
//  Purpose  : Pipeline-side bundle of the forwarding / hazard controller.
//  Ports    : ID sources, EX/MEM/WB destinations + write enables, load flag,
//             dmem handshake, flush in; fwd_sel, stall, bubble, freeze out.
//             master = pipeline side, slave = controller side.
//  Revision : 1.0  initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5
);
    logic                          i_id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] i_id_rs;
    logic [NUM_SRC-1:0]            i_id_rs_used;
    logic [REG_ADDR_W-1:0]         i_ex_rd;
    logic [REG_ADDR_W-1:0]         i_mem_rd;
    logic [REG_ADDR_W-1:0]         i_wb_rd;
    logic                          i_ex_reg_write;
    logic                          i_mem_reg_write;
    logic                          i_wb_reg_write;
    logic                          i_ex_mem_read;
    logic                          i_dmem_req;
    logic                          i_dmem_ready;
    logic                          i_flush;
    logic [NUM_SRC*2-1:0]          o_fwd_sel;
    logic                          o_stall_id;
    logic                          o_bubble_ex;
    logic                          o_freeze;

    modport master (
        output i_id_valid, i_id_rs, i_id_rs_used, i_ex_rd, i_mem_rd, i_wb_rd,
               i_ex_reg_write, i_mem_reg_write, i_wb_reg_write, i_ex_mem_read,
               i_dmem_req, i_dmem_ready, i_flush,
        input  o_fwd_sel, o_stall_id, o_bubble_ex, o_freeze
    );

    modport slave (
        input  i_id_valid, i_id_rs, i_id_rs_used, i_ex_rd, i_mem_rd, i_wb_rd,
               i_ex_reg_write, i_mem_reg_write, i_wb_reg_write, i_ex_mem_read,
               i_dmem_req, i_dmem_ready, i_flush,
        output o_fwd_sel, o_stall_id, o_bubble_ex, o_freeze
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_match.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_match
//  Purpose  : Per-slot forwarding match and priority encoder.
//  Ports    : one source index + used flag, EX/MEM/WB rd + write enables,
//             EX load flag in; next select code and load-use flag out.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_match
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  wire logic                  i_id_valid,
    input  wire logic                  i_rs_used,
    input  wire logic [REG_ADDR_W-1:0] i_rs,
    input  wire logic [REG_ADDR_W-1:0] i_ex_rd,
    input  wire logic                  i_ex_reg_write,
    input  wire logic                  i_ex_mem_read,
    input  wire logic [REG_ADDR_W-1:0] i_mem_rd,
    input  wire logic                  i_mem_reg_write,
    input  wire logic [REG_ADDR_W-1:0] i_wb_rd,
    input  wire logic                  i_wb_reg_write,
    output logic [1:0]                 o_sel,
    output logic                       o_load_use
);
    localparam logic [REG_ADDR_W-1:0] c_ZERO = REG_ADDR_W'(REG_ZERO);

    logic w_live;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;

    assign w_live    = i_id_valid & i_rs_used;
    assign w_hit_ex  = w_live & i_ex_reg_write  & (i_ex_rd  != c_ZERO) & (i_ex_rd  == i_rs);
    assign w_hit_mem = w_live & i_mem_reg_write & (i_mem_rd != c_ZERO) & (i_mem_rd == i_rs);
    assign w_hit_wb  = w_live & i_wb_reg_write  & (i_wb_rd  != c_ZERO) & (i_wb_rd  == i_rs);

    // Youngest producer wins.
    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_ex)       o_sel = FWD_EXMEM;
        else if (w_hit_mem) o_sel = FWD_MEMWB;
        else if (w_hit_wb)  o_sel = FWD_WB;
    end

    assign o_load_use = w_hit_ex & i_ex_mem_read;

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Purpose  : Forwarding and hazard controller for the 5-stage RV32 pipeline.
//             Resolves forwarding in ID, registers per-slot selects into
//             ID/EX, inserts load-use bubbles and freezes on dmem waits.
//  Ports    : i_clk, i_rst (sync, active high), bus (fwd_hazard_ctrl_if.slave)
//             Optional (FWD_HAZARD_PERF_EN): o_perf_bubbles, o_perf_freeze,
//             o_perf_fwd 32-bit wrapping event counters.
//  Revision : 1.0  initial release
// ============================================================================
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_BUBBLES = 1
) (
    input  wire logic         i_clk,
    input  wire logic         i_rst,
    fwd_hazard_ctrl_if.slave  bus
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]       o_perf_bubbles,
    output logic [31:0]       o_perf_freeze,
    output logic [31:0]       o_perf_fwd
`endif
);
    localparam logic [1:0] c_ST_RUN    = RUN;
    localparam logic [1:0] c_ST_BUBBLE = BUBBLE;
    localparam logic [1:0] c_ST_WAIT   = WAIT;
    localparam logic [1:0] c_CNT_INIT  = 2'(LOAD_BUBBLES - 1);

    logic [1:0]           r_state;
    logic [1:0]           r_cnt;
    logic [NUM_SRC*2-1:0] r_fwd_sel;
    logic [NUM_SRC*2-1:0] w_sel_next;
    logic [NUM_SRC-1:0]   w_load_use;
    logic                 w_hazard;
    logic                 w_mem_wait;
    logic                 w_stall;
    logic                 w_bubble;
    logic                 w_freeze;

    generate
        for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
            fwd_match #(.REG_ADDR_W(REG_ADDR_W)) u_match (
                .i_id_valid      (bus.i_id_valid),
                .i_rs_used       (bus.i_id_rs_used[k]),
                .i_rs            (bus.i_id_rs[k*REG_ADDR_W +: REG_ADDR_W]),
                .i_ex_rd         (bus.i_ex_rd),
                .i_ex_reg_write  (bus.i_ex_reg_write),
                .i_ex_mem_read   (bus.i_ex_mem_read),
                .i_mem_rd        (bus.i_mem_rd),
                .i_mem_reg_write (bus.i_mem_reg_write),
                .i_wb_rd         (bus.i_wb_rd),
                .i_wb_reg_write  (bus.i_wb_reg_write),
                .o_sel           (w_sel_next[k*2 +: 2]),
                .o_load_use      (w_load_use[k])
            );
        end
    endgenerate

    assign w_hazard   = |w_load_use;
    assign w_mem_wait = bus.i_dmem_req & ~bus.i_dmem_ready;

    // Memory wait outranks flush, flush outranks load-use. A flush while
    // bubbling aborts the bubble in the same cycle.
    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        w_freeze = 1'b0;
        if (!i_rst) begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_mem_wait) begin
                        w_freeze = 1'b1;
                    end else if (!bus.i_flush && w_hazard) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                c_ST_BUBBLE: begin
                    if (w_mem_wait) begin
                        w_freeze = 1'b1;
                    end else if (!bus.i_flush) begin
                        w_stall  = 1'b1;
                        w_bubble = 1'b1;
                    end
                end
                c_ST_WAIT: w_freeze = ~bus.i_dmem_ready;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= c_ST_RUN;
            r_cnt     <= 2'd0;
            r_fwd_sel <= '0;
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (w_mem_wait) begin
                        r_state <= c_ST_WAIT;
                    end else if (bus.i_flush) begin
                        r_fwd_sel <= '0;
                    end else if (w_hazard) begin
                        r_fwd_sel <= '0;
                        if (LOAD_BUBBLES > 1) begin
                            r_cnt   <= c_CNT_INIT;
                            r_state <= c_ST_BUBBLE;
                        end
                    end else begin
                        r_fwd_sel <= w_sel_next;
                    end
                end
                c_ST_BUBBLE: begin
                    if (w_mem_wait) begin
                        r_state <= c_ST_WAIT;       // counter kept for resume
                    end else if (bus.i_flush) begin
                        r_state   <= c_ST_RUN;
                        r_cnt     <= 2'd0;
                        r_fwd_sel <= '0;
                    end else begin
                        r_fwd_sel <= '0;
                        r_cnt     <= r_cnt - 2'd1;
                        if (r_cnt == 2'd1) r_state <= c_ST_RUN;
                    end
                end
                c_ST_WAIT: begin
                    if (bus.i_dmem_ready)
                        r_state <= (r_cnt != 2'd0) ? c_ST_BUBBLE : c_ST_RUN;
                end
                default: r_state <= c_ST_RUN;
            endcase
        end
    end

    assign bus.o_fwd_sel   = r_fwd_sel;
    assign bus.o_stall_id  = w_stall;
    assign bus.o_bubble_ex = w_bubble;
    assign bus.o_freeze    = w_freeze;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_freeze;
    logic [31:0] r_perf_fwd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_bubbles <= 32'd0;
            r_perf_freeze  <= 32'd0;
            r_perf_fwd     <= 32'd0;
        end else begin
            if (w_bubble)    r_perf_bubbles <= r_perf_bubbles + 32'd1;
            if (w_freeze)    r_perf_freeze  <= r_perf_freeze + 32'd1;
            if (|w_sel_next) r_perf_fwd     <= r_perf_fwd + 32'd1;
        end
    end

    assign o_perf_bubbles = r_perf_bubbles;
    assign o_perf_freeze  = r_perf_freeze;
    assign o_perf_fwd     = r_perf_fwd;
`else
    // Counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fwd_hazard_ctrl
//  Purpose  : Directed self-checking bench. dut1 uses LOAD_BUBBLES=1, dut3
//             uses LOAD_BUBBLES=3; both see the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [9:0] id_rs;
    logic [1:0] rs_used;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_we, mem_we, wb_we, ex_load;
    logic       dmem_req, dmem_ready, flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.NUM_SRC(2), .REG_ADDR_W(5)) bus1 ();
    fwd_hazard_ctrl_if #(.NUM_SRC(2), .REG_ADDR_W(5)) bus3 ();

    assign bus1.i_id_valid      = id_valid;
    assign bus1.i_id_rs         = id_rs;
    assign bus1.i_id_rs_used    = rs_used;
    assign bus1.i_ex_rd         = ex_rd;
    assign bus1.i_mem_rd        = mem_rd;
    assign bus1.i_wb_rd         = wb_rd;
    assign bus1.i_ex_reg_write  = ex_we;
    assign bus1.i_mem_reg_write = mem_we;
    assign bus1.i_wb_reg_write  = wb_we;
    assign bus1.i_ex_mem_read   = ex_load;
    assign bus1.i_dmem_req      = dmem_req;
    assign bus1.i_dmem_ready    = dmem_ready;
    assign bus1.i_flush         = flush;

    assign bus3.i_id_valid      = id_valid;
    assign bus3.i_id_rs         = id_rs;
    assign bus3.i_id_rs_used    = rs_used;
    assign bus3.i_ex_rd         = ex_rd;
    assign bus3.i_mem_rd        = mem_rd;
    assign bus3.i_wb_rd         = wb_rd;
    assign bus3.i_ex_reg_write  = ex_we;
    assign bus3.i_mem_reg_write = mem_we;
    assign bus3.i_wb_reg_write  = wb_we;
    assign bus3.i_ex_mem_read   = ex_load;
    assign bus3.i_dmem_req      = dmem_req;
    assign bus3.i_dmem_ready    = dmem_ready;
    assign bus3.i_flush         = flush;

    fwd_hazard_ctrl #(.NUM_SRC(2), .REG_ADDR_W(5), .LOAD_BUBBLES(1)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    fwd_hazard_ctrl #(.NUM_SRC(2), .REG_ADDR_W(5), .LOAD_BUBBLES(3)) dut3 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus3.slave)
    );

    task automatic idle();
        id_valid = 1'b0; id_rs = 10'd0; rs_used = 2'b00;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        ex_we = 1'b0; mem_we = 1'b0; wb_we = 1'b0; ex_load = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b1; flush = 1'b0;
    endtask

    // Advance one clock; returns 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        id_valid = 1'b1; id_rs = 10'd7; rs_used = 2'b01;
        ex_rd = 5'd7; ex_we = 1'b1; ex_load = 1'b1;
        dmem_req = 1'b1; dmem_ready = 1'b0;
        cyc(); cyc();
        checks++; if (bus1.o_stall_id !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus1.o_stall_id); end
        checks++; if (bus1.o_bubble_ex !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%b exp=0", bus1.o_bubble_ex); end
        checks++; if (bus1.o_freeze !== 1'b0) begin failures++; $display("FAIL reset_freeze got=%b exp=0", bus1.o_freeze); end
        checks++; if (bus1.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL reset_sel1 got=%b exp=0000", bus1.o_fwd_sel); end
        checks++; if (bus3.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL reset_sel3 got=%b exp=0000", bus3.o_fwd_sel); end
        rst = 1'b0;
        idle();
        cyc();
    endtask

    task automatic test_fwd_exmem();
        idle();
        id_valid = 1'b1; id_rs = {5'd0, 5'd5}; rs_used = 2'b01;
        ex_rd = 5'd5; ex_we = 1'b1;
        #2;
        checks++; if (bus1.o_stall_id !== 1'b0) begin failures++; $display("FAIL exmem_stall got=%b exp=0", bus1.o_stall_id); end
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0001) begin failures++; $display("FAIL exmem_sel got=%b exp=0001", bus1.o_fwd_sel); end
    endtask

    task automatic test_load_use_1();
        idle();
        id_valid = 1'b1; id_rs = {5'd7, 5'd0}; rs_used = 2'b10;
        ex_rd = 5'd7; ex_we = 1'b1; ex_load = 1'b1;
        #2;
        checks++; if (bus1.o_stall_id !== 1'b1) begin failures++; $display("FAIL lu1_stall got=%b exp=1", bus1.o_stall_id); end
        checks++; if (bus1.o_bubble_ex !== 1'b1) begin failures++; $display("FAIL lu1_bubble got=%b exp=1", bus1.o_bubble_ex); end
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL lu1_sel_bubble got=%b exp=0000", bus1.o_fwd_sel); end
        ex_rd = 5'd0; ex_we = 1'b0; ex_load = 1'b0;
        mem_rd = 5'd7; mem_we = 1'b1;
        #2;
        checks++; if (bus1.o_stall_id !== 1'b0) begin failures++; $display("FAIL lu1_release got=%b exp=0", bus1.o_stall_id); end
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b1000) begin failures++; $display("FAIL lu1_sel_mem got=%b exp=1000", bus1.o_fwd_sel); end
    endtask

    task automatic test_load_use_3_wait();
        pulse_reset();
        id_valid = 1'b1; id_rs = {5'd0, 5'd7}; rs_used = 2'b01;
        ex_rd = 5'd7; ex_we = 1'b1; ex_load = 1'b1;
        #2;
        checks++; if (bus3.o_stall_id !== 1'b1) begin failures++; $display("FAIL lu3_b1_stall got=%b exp=1", bus3.o_stall_id); end
        checks++; if (bus3.o_bubble_ex !== 1'b1) begin failures++; $display("FAIL lu3_b1_bubble got=%b exp=1", bus3.o_bubble_ex); end
        cyc();
        ex_rd = 5'd0; ex_we = 1'b0; ex_load = 1'b0;
        mem_rd = 5'd7; mem_we = 1'b1;
        #2;
        checks++; if (bus3.o_bubble_ex !== 1'b1) begin failures++; $display("FAIL lu3_b2_bubble got=%b exp=1", bus3.o_bubble_ex); end
        cyc();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #2;
        checks++; if (bus3.o_freeze !== 1'b1) begin failures++; $display("FAIL lu3_wait1_freeze got=%b exp=1", bus3.o_freeze); end
        cyc();
        #2;
        checks++; if (bus3.o_freeze !== 1'b1) begin failures++; $display("FAIL lu3_wait2_freeze got=%b exp=1", bus3.o_freeze); end
        cyc();
        dmem_ready = 1'b1;
        #2;
        checks++; if (bus3.o_freeze !== 1'b0) begin failures++; $display("FAIL lu3_ready_freeze got=%b exp=0", bus3.o_freeze); end
        cyc();
        dmem_req = 1'b0;
        #2;
        checks++; if (bus3.o_bubble_ex !== 1'b1) begin failures++; $display("FAIL lu3_b3_bubble got=%b exp=1", bus3.o_bubble_ex); end
        cyc();
        checks++; if (bus3.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL lu3_b3_sel got=%b exp=0000", bus3.o_fwd_sel); end
        #2;
        checks++; if (bus3.o_bubble_ex !== 1'b0) begin failures++; $display("FAIL lu3_done_bubble got=%b exp=0", bus3.o_bubble_ex); end
        checks++; if (bus3.o_stall_id !== 1'b0) begin failures++; $display("FAIL lu3_done_stall got=%b exp=0", bus3.o_stall_id); end
        cyc();
        checks++; if (bus3.o_fwd_sel !== 4'b0010) begin failures++; $display("FAIL lu3_done_sel got=%b exp=0010", bus3.o_fwd_sel); end
    endtask

    task automatic test_x0_unused();
        idle();
        id_valid = 1'b1; id_rs = {5'd12, 5'd0}; rs_used = 2'b01;
        ex_rd = 5'd0; ex_we = 1'b1; ex_load = 1'b1;
        mem_rd = 5'd12; mem_we = 1'b1;
        #2;
        checks++; if (bus1.o_stall_id !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", bus1.o_stall_id); end
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL x0_sel got=%b exp=0000", bus1.o_fwd_sel); end
    endtask

    task automatic test_priority();
        idle();
        id_valid = 1'b1; id_rs = {5'd0, 5'd9}; rs_used = 2'b01;
        ex_rd = 5'd9; mem_rd = 5'd9; wb_rd = 5'd9;
        ex_we = 1'b1; mem_we = 1'b1; wb_we = 1'b1;
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0001) begin failures++; $display("FAIL prio_ex got=%b exp=0001", bus1.o_fwd_sel); end
        ex_we = 1'b0;
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0010) begin failures++; $display("FAIL prio_mem got=%b exp=0010", bus1.o_fwd_sel); end
        mem_we = 1'b0;
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0011) begin failures++; $display("FAIL prio_wb got=%b exp=0011", bus1.o_fwd_sel); end
        wb_we = 1'b0;
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL prio_rf got=%b exp=0000", bus1.o_fwd_sel); end
    endtask

    task automatic test_flush();
        pulse_reset();
        id_valid = 1'b1; id_rs = {5'd0, 5'd4}; rs_used = 2'b01;
        ex_rd = 5'd4; ex_we = 1'b1;
        cyc();
        checks++; if (bus3.o_fwd_sel !== 4'b0001) begin failures++; $display("FAIL flush_pre_sel got=%b exp=0001", bus3.o_fwd_sel); end
        flush = 1'b1;
        cyc();
        checks++; if (bus3.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL flush_run_sel got=%b exp=0000", bus3.o_fwd_sel); end
        id_rs = {5'd0, 5'd7}; ex_rd = 5'd7; ex_load = 1'b1;
        #2;
        checks++; if (bus3.o_stall_id !== 1'b0) begin failures++; $display("FAIL flush_beats_lu got=%b exp=0", bus3.o_stall_id); end
        cyc();
        flush = 1'b0;
        cyc();                      // load-use taken: dut3 enters BUBBLE
        flush = 1'b1; ex_we = 1'b0; ex_load = 1'b0;
        cyc();                      // flush aborts the bubble sequence
        flush = 1'b0;
        id_rs = {5'd0, 5'd4}; ex_rd = 5'd4; ex_we = 1'b1;
        #2;
        checks++; if (bus3.o_bubble_ex !== 1'b0) begin failures++; $display("FAIL flush_abort_bubble got=%b exp=0", bus3.o_bubble_ex); end
        checks++; if (bus3.o_stall_id !== 1'b0) begin failures++; $display("FAIL flush_abort_stall got=%b exp=0", bus3.o_stall_id); end
        cyc();
        checks++; if (bus3.o_fwd_sel !== 4'b0001) begin failures++; $display("FAIL flush_after_sel got=%b exp=0001", bus3.o_fwd_sel); end
    endtask

    task automatic test_reset_mid_wait();
        pulse_reset();
        id_valid = 1'b1; id_rs = {5'd0, 5'd5}; rs_used = 2'b01;
        ex_rd = 5'd5; ex_we = 1'b1;
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0001) begin failures++; $display("FAIL rstw_pre_sel got=%b exp=0001", bus1.o_fwd_sel); end
        ex_we = 1'b0;
        dmem_req = 1'b1; dmem_ready = 1'b0;
        #2;
        checks++; if (bus1.o_freeze !== 1'b1) begin failures++; $display("FAIL rstw_freeze got=%b exp=1", bus1.o_freeze); end
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0001) begin failures++; $display("FAIL rstw_hold_sel got=%b exp=0001", bus1.o_fwd_sel); end
        rst = 1'b1;
        #2;
        checks++; if (bus1.o_freeze !== 1'b0) begin failures++; $display("FAIL rstw_in_rst_freeze got=%b exp=0", bus1.o_freeze); end
        checks++; if (bus1.o_stall_id !== 1'b0) begin failures++; $display("FAIL rstw_in_rst_stall got=%b exp=0", bus1.o_stall_id); end
        cyc();
        checks++; if (bus1.o_fwd_sel !== 4'b0000) begin failures++; $display("FAIL rstw_sel got=%b exp=0000", bus1.o_fwd_sel); end
        rst = 1'b0;
        dmem_req = 1'b0; dmem_ready = 1'b0;
        #2;
        checks++; if (bus1.o_freeze !== 1'b0) begin failures++; $display("FAIL rstw_after_freeze got=%b exp=0", bus1.o_freeze); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_fwd_exmem();
        test_load_use_1();
        test_load_use_3_wait();
        test_x0_unused();
        test_priority();
        test_flush();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
